// File: rtl/srom_stream_reader_4_bit.sv
// Read client for the 4-bit x 16 single-port SROM: walks an address range and streams words out.
// Latency: 2 cycles from accepted start to first valid word. Backpressure: issue stalls when the 2-entry capture buffer could overflow.
// Optional feature: define SROM_READER_CHECKSUM_EN to add Checksum_Out (XOR of all words handed off in the transfer).
module srom_stream_reader_4_bit #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic [ADDR_WIDTH-1:0] Start_Address_In,
  input  logic [ADDR_WIDTH:0]   Length_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  SROM_Enable_Out,
  output logic                  SROM_Read_Enable_Out,
  output logic [ADDR_WIDTH-1:0] SROM_Address_Out,
  input  logic [DATA_WIDTH-1:0] SROM_Read_Data_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  output logic                  Data_Valid_Out,
  input  logic                  Data_Ready_In,
  output logic                  Data_Last_Out
`ifdef SROM_READER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] Checksum_Out
`endif
);

  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] DEPTH = LEN_W'(1 << ADDR_WIDTH);
  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [LEN_W-1:0]                issue_cnt_q;
  logic [LEN_W-1:0]                out_cnt_q;
  logic                            in_flight_q;
  logic [1:0][DATA_WIDTH-1:0]      buf_q;
  logic                            wr_ptr_q;
  logic                            rd_ptr_q;
  logic [1:0]                      occ_q;

  logic                            start_ok;
  logic [LEN_W-1:0]                len_clamped;
  logic                            pop;
  logic                            last_pop;
  logic                            room;
  logic                            issue;
  logic [2:0]                      committed;

  // Start handling and stream handshake decode
  always_comb begin
    start_ok    = (state_q == IDLE) && Start_In && (Length_In != '0);
    len_clamped = (Length_In > DEPTH) ? DEPTH : Length_In;
    pop         = (occ_q != 2'd0) && Data_Ready_In;
    last_pop    = pop && (out_cnt_q == ONE);
  end

  // Words already buffered plus the one in the SROM pipe, minus what leaves this edge
  always_comb begin
    committed = {1'b0, occ_q} + {2'b0, in_flight_q} - {2'b0, pop};
    room      = (committed < 3'd2);
    issue     = (state_q == RUN) && (issue_cnt_q != '0) && room;
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    Busy_Out             = 1'b0;
    Done_Out             = 1'b0;
    SROM_Enable_Out      = 1'b0;
    SROM_Read_Enable_Out = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = RUN;
        end
      end
      RUN: begin
        Busy_Out             = 1'b1;
        SROM_Enable_Out      = 1'b1;
        SROM_Read_Enable_Out = 1'b1;
        if (last_pop) begin
          state_d = DONE;
        end
      end
      DONE: begin
        Done_Out = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address walk and counters
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      addr_q      <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      in_flight_q <= 1'b0;
    end else begin
      in_flight_q <= issue;
      if (start_ok) begin
        addr_q      <= Start_Address_In;
        issue_cnt_q <= len_clamped;
        out_cnt_q   <= len_clamped;
      end else begin
        if (issue) begin
          addr_q      <= addr_q + 1'b1;
          issue_cnt_q <= issue_cnt_q - ONE;
        end
        if (pop) begin
          out_cnt_q <= out_cnt_q - ONE;
        end
      end
    end
  end

  // Capture buffer: a word is written only on the edge after its own issue
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      buf_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (in_flight_q) begin
        buf_q[wr_ptr_q] <= SROM_Read_Data_In;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, in_flight_q} - {1'b0, pop};
    end
  end

  always_comb begin
    SROM_Address_Out = addr_q;
    Data_Out         = buf_q[rd_ptr_q];
    Data_Valid_Out   = (occ_q != 2'd0);
    Data_Last_Out    = (occ_q != 2'd0) && (state_q == RUN) && (out_cnt_q == ONE);
  end

`ifdef SROM_READER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum_q;

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      checksum_q <= '0;
    end else if (start_ok) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q ^ Data_Out;
    end
  end

  assign Checksum_Out = checksum_q;
`endif

endmodule

// File: doc/srom_stream_reader_4_bit.md
# srom_stream_reader_4_bit

Read-side client for the 4-bit, 16-deep single-port SROM. On a start command it walks a contiguous address range (wrapping at 0xF), drives the SROM enable/read/address pins, captures the one-cycle-latency read data, and presents it as a valid/ready stream with a last flag. A 2-entry capture buffer absorbs SROM latency so downstream backpressure never loses a word.

## Interface
- DATA_WIDTH, 4, SROM word width; must match the SROM.
- ADDR_WIDTH, 4, SROM address width; depth = 2**ADDR_WIDTH.
- Clk_In  input  1  clock, all logic on rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Start_In  input  1  start request, sampled in IDLE only.
- Start_Address_In  input  ADDR_WIDTH  first address of the transfer.
- Length_In  input  ADDR_WIDTH+1  word count, legal 1..16; 0 ignored; 17..31 clamped to 16.
- Busy_Out  output  1  high from the cycle after an accepted Start until Done_Out.
- Done_Out  output  1  one-cycle pulse after the final word handshake.
- SROM_Enable_Out  output  1  to SROM Enable_In.
- SROM_Read_Enable_Out  output  1  to SROM Port_1_Read_Enable_In.
- SROM_Address_Out  output  ADDR_WIDTH  to SROM Port_1_Address_In.
- SROM_Read_Data_In  input  DATA_WIDTH  from SROM Port_1_Read_Data_Out; Z when SROM is not enabled.
- Data_Out  output  DATA_WIDTH  stream data, head of capture buffer.
- Data_Valid_Out  output  1  capture buffer non-empty.
- Data_Ready_In  input  1  downstream accepts; handshake = Valid & Ready at a rising edge.
- Data_Last_Out  output  1  high with Valid when the head word is the transfer's final word.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: Start_In=1 with nonzero Length latches address, clamped length into issue and output counters; next state RUN. Start_In in RUN/DONE ignored.
- RUN: SROM_Enable_Out and SROM_Read_Enable_Out held high continuously (SROM output never Z while a word is in flight). An issue occurs at an edge when issue counter > 0 and (buffer occupancy + in-flight − pop this edge) < 2; on issue the address increments mod 16 and issue counter decrements. When not issuing, address holds.
- In-flight flag set at each issue edge; at the next edge SROM_Read_Data_In is written into the buffer and the flag clears. Re-reads of a held address are not captured.
- Buffer: 2 entries, simultaneous push and pop allowed; never overflows by construction.
- Each handshake decrements output counter; handshake on the word with counter=1 → DONE.
- DONE: enables low, Done_Out=1 for one cycle, then IDLE.
- Data_Out holds its value while Valid & !Ready.

## Timing
- Reset values: Busy_Out 0, Done_Out 0, SROM_Enable_Out 0, SROM_Read_Enable_Out 0, SROM_Address_Out 0, Data_Out 0, Data_Valid_Out 0, Data_Last_Out 0; state IDLE; buffer empty.
- Start sampled at edge 0 → enables high and address = Start_Address after edge 0; SROM registers at edge 1; capture at edge 2; Data_Valid_Out high after edge 2 (2-cycle start-to-valid).
- With Data_Ready_In held high: one word per cycle; N-word transfer ends with Done_Out in cycle N+2 after Start edge.
- Ready low: at most 2 words buffered, issue stalls; resumes the edge after Ready returns.
- Wrap: Start 0xE, Length 4 reads 0xE,0xF,0x0,0x1.
- Reset mid-RUN: immediate return to reset values; no Done_Out; buffered data discarded.

## Configuration
- SROM_READER_CHECKSUM_EN defined: extra output Checksum_Out (DATA_WIDTH), XOR of all words handshaken in the current transfer; cleared to 0 on accepted Start and on reset; final value stable from Done_Out until next Start.
- Not defined: port and logic absent; all other behaviour identical.

## Test plan
- Reset then Start, address 0x0, Length 16, Ready=1 → Data_Out = mem[0x0..0xF] on 16 consecutive cycles, Last on 16th, Done one cycle later.
- Start 0xE, Length 4 → words mem[0xE], mem[0xF], mem[0x0], mem[0x1]; Last on mem[0x1].
- Start 0x3, Length 6, Ready toggled 1,0,0,1,0,1,… → exactly mem[0x3..0x8] in order, no drops/duplicates, Data_Out stable while Ready=0.
- Length 0 → no Busy, no enables, no Done; Length 20 from 0x0 → exactly 16 words.
- Reset asserted mid-transfer (after 3 words, Start 0x0 Length 10) → all outputs zero immediately; new Start 0x5 Length 2 → mem[0x5], mem[0x6].
- With SROM_READER_CHECKSUM_EN: Start 0x0 Length 4 → Checksum_Out = mem[0]^mem[1]^mem[2]^mem[3] at Done.
